data_port_arbiter: RTL and testbench

DATA_PORT_ARBITER -- requirements
Module: data_port_arbiter

---
 rtl/data_port_arbiter.sv | 106 ++++++++++
 tb/tb_data_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_port_arbiter.sv
// data_port_arbiter: two-requester data memory port arbiter with B lock bursts and in-order read return
module data_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqA,
    input  logic              reqB,
    input  logic              weA,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdataA,
    input  logic [DATA_W-1:0] wdataB,
    input  logic              lockB,
    output logic              gntA,
    output logic              gntB,
    output logic              rvalidA,
    output logic              rvalidB,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWrEn,
    input  logic [DATA_W-1:0] memRdData
);
    localparam int DEPTH = RD_LATENCY + 1;
    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    logic              r_last_b;
    logic [7:0]        r_lock_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_own;
    logic              w_locked;
    logic              w_pick_b;
    logic              w_issue_rd;

    // B wins when alone, when holding a live lock after its own grant, or when A went last
    always_comb begin
        w_locked   = reqB & lockB & r_last_b & (r_lock_cnt < LOCK_MAX);
        w_pick_b   = reqB & (~reqA | w_locked | ~r_last_b);
        gntB       = ~rst & w_pick_b;
        gntA       = ~rst & reqA & ~w_pick_b;
        w_issue_rd = (gntA & ~weA) | (gntB & ~weB);
    end

    // round-robin history: remembers which requester was granted most recently
    always_ff @(posedge clk) begin
        if (rst)
            r_last_b <= 1'b1;
        else if (gntA)
            r_last_b <= 1'b0;
        else if (gntB)
            r_last_b <= 1'b1;
    end

    // counts locked B grants that made A wait; dropping the lock or serving A restarts the run
    always_ff @(posedge clk) begin
        if (rst || gntA || !lockB)
            r_lock_cnt <= '0;
        else if (gntB && w_locked && reqA)
            r_lock_cnt <= r_lock_cnt + 8'd1;
    end

    // issue register: the winner's access reaches the memory one cycle after its grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (gntA) begin
            r_addr  <= addrA;
            r_wdata <= wdataA;
            r_we    <= weA;
        end else if (gntB) begin
            r_addr  <= addrB;
            r_wdata <= wdataB;
            r_we    <= weB;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // in-flight read tracker: the entry leaving the last stage lines up with memRdData
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2:0], w_issue_rd};
            r_own <= {r_own[DEPTH-2:0], gntB};
        end
    end

    assign rvalidA   = ~rst & r_vld[DEPTH-1] & ~r_own[DEPTH-1];
    assign rvalidB   = ~rst & r_vld[DEPTH-1] & r_own[DEPTH-1];
    assign rdata     = memRdData;
    assign memAddr   = rst ? '0 : r_addr;
    assign memWrData = rst ? '0 : r_wdata;
    assign memWrEn   = ~rst & r_we;
endmodule

// File: tb/tb_data_port_arbiter.sv
// tb_data_port_arbiter: random two-requester traffic checked against a cycle-level reference model
module tb_data_port_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int MAXL = 8;

    logic          clk, rst;
    logic          reqA, reqB, weA, weB, lockB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] wdataA, wdataB;
    logic          gntA, gntB, rvalidA, rvalidB, memWrEn;
    logic [DW-1:0] rdata, memWrData, memRdData;
    logic [AW-1:0] memAddr;

    data_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_LOCK(MAXL)) u_dut (
        .clk(clk), .rst(rst),
        .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
        .lockB(lockB), .gntA(gntA), .gntB(gntB),
        .rvalidA(rvalidA), .rvalidB(rvalidB), .rdata(rdata),
        .memAddr(memAddr), .memWrData(memWrData), .memWrEn(memWrEn),
        .memRdData(memRdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    logic [AW-1:0] hist [LAT];
    always @(posedge clk) begin
        hist[0] <= memAddr;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign memRdData = mem_word(hist[LAT-1]);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            due;
        bit            own_b;
        logic [AW-1:0] addr;
    } rsp_t;

    rsp_t q[$];
    bit            m_last_b;
    int            m_cnt;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit            pa, pb, wa, wb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;

    initial begin
        rst = 1'b1; reqA = 0; reqB = 0; weA = 0; weB = 0; lockB = 0;
        addrA = '0; addrB = '0; wdataA = '0; wdataB = '0;
        pa = 0; pb = 0; wa = 0; wb = 0; aa = '0; ab = '0; da = '0; db = '0;
        m_last_b = 1; m_cnt = 0; e_we = 0; e_addr = '0; e_wd = '0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            int  mode, pct;
            bit  lock_on, exp_a, exp_b, exp_ra, exp_rb, locked_win;
            @(posedge clk);
            #1;
            mode    = (cyc / 120) % 3;
            pct     = (mode == 0) ? 30 : 92;
            lock_on = (mode == 2) || ((cyc / 40) % 5 == 1);
            rst     = (cyc < 3) || (cyc >= 800 && cyc < 802) || cyc == 1500 || (cyc >= 1901 && cyc < 1904);
            if (!pa && $urandom_range(99) < pct) begin
                pa = 1; wa = ($urandom_range(9) < 3);
                aa = ($urandom_range(7) == 0) ? 14'h3FFF : AW'($urandom); da = $urandom;
            end
            if (!pb && $urandom_range(99) < pct) begin
                pb = 1; wb = ($urandom_range(9) < 3);
                ab = ($urandom_range(7) == 0) ? 14'h3FFF : AW'($urandom); db = $urandom;
            end
            reqA = pa; weA = wa; addrA = aa; wdataA = da;
            reqB = pb; weB = wb; addrB = ab; wdataB = db;
            lockB = pb && lock_on && ($urandom_range(19) != 0);
            #1;
            if (rst) begin
                chk("rst_gntA", gntA, 0);
                chk("rst_gntB", gntB, 0);
                chk("rst_rvalid", {rvalidA, rvalidB}, 0);
                chk("rst_wren", memWrEn, 0);
                chk("rst_addr", memAddr, 0);
                chk("rst_wdata", memWrData, 0);
                q.delete();
                m_last_b = 1; m_cnt = 0; e_we = 0; e_addr = '0; e_wd = '0;
                continue;
            end
            exp_a = 0; exp_b = 0; locked_win = 0;
            if (pa && pb) begin
                if (lockB && m_last_b && m_cnt < MAXL) begin
                    exp_b = 1; locked_win = 1;
                end else if (m_last_b)
                    exp_a = 1;
                else
                    exp_b = 1;
            end else begin
                exp_a = pa;
                exp_b = pb;
                locked_win = pb && lockB && m_last_b;
            end
            chk("gntA", gntA, exp_a);
            chk("gntB", gntB, exp_b);
            exp_ra = (q.size() > 0) && q[0].due == cyc && !q[0].own_b;
            exp_rb = (q.size() > 0) && q[0].due == cyc && q[0].own_b;
            chk("rvalidA", rvalidA, exp_ra);
            chk("rvalidB", rvalidB, exp_rb);
            if (exp_ra || exp_rb) begin
                chk("rdata", rdata, mem_word(q[0].addr));
                void'(q.pop_front());
            end
            chk("memWrEn", memWrEn, e_we);
            chk("memAddr", memAddr, e_addr);
            chk("memWrData", memWrData, e_wd);
            if (!lockB || exp_a)
                m_cnt = 0;
            else if (exp_b && locked_win && pa && m_cnt < MAXL)
                m_cnt++;
            e_we = 0;
            if (exp_a) begin
                e_we = wa; e_addr = aa; e_wd = da; m_last_b = 0; pa = 0;
                if (!wa) q.push_back('{cyc + LAT + 1, 1'b0, aa});
            end else if (exp_b) begin
                e_we = wb; e_addr = ab; e_wd = db; m_last_b = 1; pb = 0;
                if (!wb) q.push_back('{cyc + LAT + 1, 1'b1, ab});
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
